// File: rtl/display_mux.sv
// Two-digit time multiplexer feeding the seven_segment decoder, with blanking between digits.
// Optional build macro LEADING_ZERO_BLANK_EN keeps digit 1 dark while it would show zero.
module display_mux #(
    parameter int unsigned REFRESH_CYCLES = 24_000,
    parameter int unsigned BLANK_CYCLES   = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] num,
    output logic [1:0] an,
    output logic       frame
);

    localparam int unsigned MAX_LEN =
        (REFRESH_CYCLES > BLANK_CYCLES) ?
            ((REFRESH_CYCLES > 2) ? REFRESH_CYCLES : 2) :
            ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int unsigned CNT_W = $clog2(MAX_LEN);

    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   =
        CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam bit NO_BLANK = (BLANK_CYCLES == 0);

    typedef enum logic [1:0] {
        StShow0,
        StBlank0,
        StShow1,
        StBlank1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             target0;
    logic [3:0]       num_next;
    logic [1:0]       an_next;

    // A blank state with zero length is only reachable from reset and leaves on the first edge.
    always_comb begin
        last = 1'b0;
        unique case (state)
            StShow0, StShow1: last = (cnt == REFRESH_LAST);
            StBlank0, StBlank1: last = NO_BLANK || (cnt == BLANK_LAST);
        endcase
    end

    always_comb begin
        next_state = state;
        if (last) begin
            unique case (state)
                StShow0:  next_state = NO_BLANK ? StShow1 : StBlank0;
                StBlank0: next_state = StShow1;
                StShow1:  next_state = NO_BLANK ? StShow0 : StBlank1;
                StBlank1: next_state = StShow0;
            endcase
        end
    end

    // num is loaded for the digit about to be shown, so it is settled before that anode lights.
    always_comb begin
        target0  = (next_state == StShow0) || (next_state == StBlank1);
        num_next = target0 ? s0 : s1;
        an_next  = 2'b11;
        unique case (next_state)
            StShow0: an_next = 2'b10;
`ifdef LEADING_ZERO_BLANK_EN
            StShow1: an_next = (num_next == 4'h0) ? 2'b11 : 2'b01;
`else
            StShow1: an_next = 2'b01;
`endif
            StBlank0, StBlank1: an_next = 2'b11;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StBlank1;
            cnt   <= '0;
            an    <= 2'b11;
            num   <= 4'h0;
            frame <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= last ? '0 : cnt + CNT_W'(1);
            an    <= an_next;
            num   <= num_next;
            frame <= last && (next_state == StShow0);
        end
    end

endmodule

// File: tb/tb_display_mux.sv
// Scoreboard bench for display_mux: one instance with blanking, one with BLANK_CYCLES=0.
module tb_display_mux;

    localparam int R = 4;
    localparam int B = 2;

    typedef struct packed {
        logic [1:0] an;
        logic [3:0] num;
        logic       frame;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] s0, s1;
    logic [3:0] num_a, num_b;
    logic [1:0] an_a, an_b;
    logic       frame_a, frame_b;

    always #5 clk = ~clk;

    display_mux #(.REFRESH_CYCLES(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .s0(s0), .s1(s1),
        .num(num_a), .an(an_a), .frame(frame_a)
    );

    display_mux #(.REFRESH_CYCLES(R), .BLANK_CYCLES(0)) dut_nb (
        .clk(clk), .reset(reset), .s0(s0), .s1(s1),
        .num(num_b), .an(an_b), .frame(frame_b)
    );

    int   n_total = 0;
    int   n_pass  = 0;
    int   p;
    int   last_fa, last_fb;
    obs_t q_a[$];
    obs_t q_b[$];

    // Expected outputs in cycle p after reset release (p=0 is the first cycle),
    // given the inputs present during cycle p-1. Built from the position in the frame.
    function automatic obs_t model(int pp, int r, int b, logic [3:0] v0, logic [3:0] v1);
        obs_t o;
        int   lead, q, seg;
        o.an = 2'b11; o.num = 4'h0; o.frame = 1'b0;
        if (pp == 0) return o;
        lead = (b == 0) ? 1 : b;
        q = 0;
        if (pp < lead) seg = 3;
        else begin
            q = (pp - lead) % (2 * (r + b));
            if (q < r) seg = 0;
            else if (q < r + b) seg = 1;
            else if (q < 2 * r + b) seg = 2;
            else seg = 3;
        end
        o.frame = (pp >= lead) && (q == 0);
        o.num   = (seg == 0 || seg == 3) ? v0 : v1;
        if (seg == 0) o.an = 2'b10;
        else if (seg == 2) begin
`ifdef LEADING_ZERO_BLANK_EN
            o.an = (v1 == 4'h0) ? 2'b11 : 2'b01;
`else
            o.an = 2'b01;
`endif
        end
        return o;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at p=%0d: observed %0h expected %0h", tag, p, obs, exp);
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_an_a"}, 32'(an_a), 32'h3);
        check({tag, "_num_a"}, 32'(num_a), 32'h0);
        check({tag, "_frame_a"}, 32'(frame_a), 32'h0);
        check({tag, "_an_b"}, 32'(an_b), 32'h3);
        check({tag, "_num_b"}, 32'(num_b), 32'h0);
        check({tag, "_frame_b"}, 32'(frame_b), 32'h0);
    endtask

    // Asynchronous assert away from the edge, hold across one edge, release mid-cycle.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_vals("rst_async");
        @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        #2;
        reset = 1'b0;
        p = 0;
        q_a.delete();
        q_b.delete();
        last_fa = -1;
        last_fb = -1;
        check_reset_vals("rst_release");
    endtask

    task automatic step();
        obs_t ea, eb;
        q_a.push_back(model(p + 1, R, B, s0, s1));
        q_b.push_back(model(p + 1, R, 0, s0, s1));
        @(posedge clk);
        #1;
        p++;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check("an_a", 32'(an_a), 32'(ea.an));
        check("num_a", 32'(num_a), 32'(ea.num));
        check("frame_a", 32'(frame_a), 32'(ea.frame));
        check("an_b", 32'(an_b), 32'(eb.an));
        check("num_b", 32'(num_b), 32'(eb.num));
        check("frame_b", 32'(frame_b), 32'(eb.frame));
        check("an_a_not_00", 32'(an_a != 2'b00), 32'h1);
        check("an_b_not_00", 32'(an_b != 2'b00), 32'h1);
        if (frame_a === 1'b1) begin
            if (last_fa >= 0) check("frame_period_a", 32'(p - last_fa), 32'(2 * (R + B)));
            last_fa = p;
        end
        if (frame_b === 1'b1) begin
            if (last_fb >= 0) check("frame_period_b", 32'(p - last_fb), 32'(2 * R));
            last_fb = p;
        end
    endtask

    task automatic run_to(int target);
        while (p < target) step();
    endtask

    initial begin
        reset = 1'b1;
        s0 = 4'h3;
        s1 = 4'hA;
        p = 0;
        #1;
        do_reset();

        // Second cycle of the second SHOW0: change s0 mid-digit.
        run_to(15);
        s0 = 4'h7;
        run_to(45);

        // p=45 sits inside SHOW1 of the blanked instance.
        do_reset();
        run_to(30);

        s0 = 4'h5;
        s1 = 4'h0;
        run_to(60);
        s1 = 4'h2;
        run_to(80);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_mux.md
Name: display_mux

Overview:
- Two-digit time-multiplexer that sits directly upstream of the existing seven_segment decoder.
- Alternately selects one of two 4-bit hex values, drives the selected nibble to the decoder's num input, and drives the two active-low common-anode enables.
- Inserts a blanking interval between digits so the outgoing digit never ghosts onto the incoming one.
- Targets the 12 MHz board clock. Full refresh is well above flicker threshold.

Parameters:
- REFRESH_CYCLES, 24_000, clk cycles each digit is lit per visit (2 ms at 12 MHz). Must be ≥1.
- BLANK_CYCLES, 120, clk cycles both anodes are off between digits (10 us). 0 is legal and removes the blank states.
- Counter width: localparam, $clog2 of max(REFRESH_CYCLES, BLANK_CYCLES, 2).

Ports:
- clk  input  1  system clock, 12 MHz
- reset  input  1  asynchronous, active-high reset
- s0  input  4  hex value for digit 0 (right digit)
- s1  input  4  hex value for digit 1 (left digit)
- num  output  4  nibble to the seven_segment decoder
- an  output  2  anode enables, active-low; an[0] drives digit 0, an[1] drives digit 1
- frame  output  1  one-cycle pulse on entry to SHOW0

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high. All state and outputs are registered.
- Reset values: state=BLANK1, cnt=0, an=2'b11, num=4'h0, frame=0.
- FSM states, in order: SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0 ...
- Dwell: SHOWk lasts REFRESH_CYCLES cycles. BLANKk lasts BLANK_CYCLES cycles.
- Counting: cnt counts 0..len-1 within a state. The transition occurs on the edge where cnt==len-1, and cnt clears to 0 on every transition.
- BLANK_CYCLES==0: SHOW0 goes directly to SHOW1 and back. BLANK states are never entered except the reset state, which exits on the first edge.
- an tracks the current state, updated on the same edge as the state:
  - SHOW0: an=2'b10
  - SHOW1: an=2'b01
  - BLANK0, BLANK1: an=2'b11
  - Exactly one anode low, or none. Never 2'b00.
- Target digit: SHOW0 and BLANK1 target digit 0. SHOW1 and BLANK0 target digit 1.
- num update:
  - num <= s0 when the next state targets digit 0, else s1.
  - num is therefore pre-loaded during the blank before its digit lights.
  - Input changes reach num 1 cycle later, including mid-SHOW.
- frame: 1 for exactly the first cycle of each SHOW0 (registered with the state), else 0.
- Period: 2*(REFRESH_CYCLES+BLANK_CYCLES) cycles between frame pulses.
- Reset asserted mid-operation: outputs immediately (asynchronously) return to reset values. Sequence restarts from BLANK1 after release.
- s0/s1 are static switch or register inputs. No synchronisation is required for display purposes.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: if the registered num equals 4'h0 while in SHOW1, an stays 2'b11 for that cycle, so the left digit is dark when s1==0. Timing, num, and frame are unchanged.
- Undefined: digit 1 always lights in SHOW1, showing "0" when s1==0.

Test Plan:
Run all scenarios with REFRESH_CYCLES=4, BLANK_CYCLES=2 unless noted.
- Reset release with s0=4'h3, s1=4'hA:
  - Cycles 1-2: an=11.
  - Cycles 3-6: an=10, num=3. frame=1 in cycle 3 only.
  - Cycles 7-8: an=11, num=A.
  - Cycles 9-12: an=01, num=A.
  - Cycles 13-14: an=11, num=3.
  - Repeats with frame every 12 cycles.
- Change s0 from 3 to 7 in the 2nd cycle of SHOW0 -> num=7 on the next edge, an stays 10, dwell unaltered.
- Assert reset mid-SHOW1 for 1 cycle -> an=11, num=0, frame=0 immediately. After release, 2 blank cycles, then SHOW0 with frame pulse.
- Rebuild with BLANK_CYCLES=0 -> an alternates 10/01 every 4 cycles, never 11 after the first post-reset cycle. frame period is 8.
- With LEADING_ZERO_BLANK_EN, s1=0, s0=5 -> an never 01; an=10 for 4 of every 12 cycles. With s1=2 the same build shows an=01 normally.
- Throughout every run, assert an!=2'b00 every cycle and exactly one frame pulse per period.
